// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with a serial shifter and valid/ready output handshake.
// Non-shift ops register in one edge; shifts iterate SHIFT_STEP bits per cycle.
module ex_stage #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] reg1_in,
    input  logic [31:0] reg2_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rsd_in,
    input  logic        write_rsd_in,
    input  logic [5:0]  cmdtype_in,
    input  logic        mem_ready_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [5:0]  cmdtype_out,
    output logic [4:0]  rsd_out,
    output logic        write_rsd_out,
    output logic [31:0] alu_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] store_data_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_target_out
);
    localparam logic [5:0] CMD_LUI = 6'd1, CMD_AUIPC = 6'd2, CMD_JAL = 6'd3, CMD_JALR = 6'd4,
        CMD_BEQ = 6'd5, CMD_BNE = 6'd6, CMD_BLT = 6'd7, CMD_BGE = 6'd8, CMD_BLTU = 6'd9,
        CMD_BGEU = 6'd10, CMD_LB = 6'd11, CMD_LH = 6'd12, CMD_LW = 6'd13, CMD_LBU = 6'd14,
        CMD_LHU = 6'd15, CMD_SB = 6'd16, CMD_SH = 6'd17, CMD_SW = 6'd18, CMD_ADDI = 6'd19,
        CMD_SLTI = 6'd20, CMD_SLTIU = 6'd21, CMD_XORI = 6'd22, CMD_ORI = 6'd23, CMD_ANDI = 6'd24,
        CMD_SLLI = 6'd25, CMD_SRLI = 6'd26, CMD_SRAI = 6'd27, CMD_ADD = 6'd28, CMD_SUB = 6'd29,
        CMD_SLL = 6'd30, CMD_SLT = 6'd31, CMD_SLTU = 6'd32, CMD_XOR = 6'd33, CMD_SRL = 6'd34,
        CMD_SRA = 6'd35, CMD_OR = 6'd36, CMD_AND = 6'd37;
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d, wr_q, wr_d, br_q, br_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [4:0]  rsd_q, rsd_d, sh_rem_q, sh_rem_d;
    logic [1:0]  sh_mode_q, sh_mode_d;
    logic [31:0] alu_q, alu_d, addr_q, addr_d, sdata_q, sdata_d, tgt_q, tgt_d, sh_val_q, sh_val_d;

    logic        stall, take, sh_imm, is_shift, sh_done, r_br, r_wr;
    logic [4:0]  shamt, amt, rem_next;
    logic [1:0]  mode;
    logic [31:0] sum_ri, sra_val, sh_next, r_alu, r_tgt;

    assign stall    = (state_q == SHIFT) | (valid_q & ~mem_ready_in);
    // An instruction arriving while a taken-branch pulse is out is on the wrong path.
    assign take     = ~stall & (|cmdtype_in) & ~br_q;
    assign sh_imm   = cmdtype_in inside {CMD_SLLI, CMD_SRLI, CMD_SRAI};
    assign is_shift = sh_imm | (cmdtype_in inside {CMD_SLL, CMD_SRL, CMD_SRA});
    assign shamt    = sh_imm ? imm_in[4:0] : reg2_in[4:0];
    assign mode     = (cmdtype_in inside {CMD_SLL, CMD_SLLI}) ? 2'd0 :
                      (cmdtype_in inside {CMD_SRL, CMD_SRLI}) ? 2'd1 : 2'd2;
    assign amt      = (sh_rem_q < STEP) ? sh_rem_q : STEP;
    assign sra_val  = $signed(sh_val_q) >>> amt;
    assign sh_next  = (sh_mode_q == 2'd0) ? sh_val_q << amt :
                      (sh_mode_q == 2'd1) ? sh_val_q >> amt : sra_val;
    assign rem_next = sh_rem_q - amt;
    assign sh_done  = (state_q == SHIFT) && (rem_next == 5'd0);
    assign sum_ri   = reg1_in + imm_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            wr_q      <= 1'b0;
            br_q      <= 1'b0;
            cmd_q     <= '0;
            rsd_q     <= '0;
            alu_q     <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            tgt_q     <= '0;
            sh_val_q  <= '0;
            sh_rem_q  <= '0;
            sh_mode_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            wr_q      <= wr_d;
            br_q      <= br_d;
            cmd_q     <= cmd_d;
            rsd_q     <= rsd_d;
            alu_q     <= alu_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            tgt_q     <= tgt_d;
            sh_val_q  <= sh_val_d;
            sh_rem_q  <= sh_rem_d;
            sh_mode_q <= sh_mode_d;
        end
    end

    always_comb begin
        state_d = (state_q == SHIFT) ? (sh_done ? IDLE : SHIFT) :
                  (valid_q & ~mem_ready_in) ? HOLD :
                  (take & is_shift) ? SHIFT : IDLE;
    end

    always_comb begin
        r_alu = '0;
        r_br  = 1'b0;
        r_tgt = pc_in + imm_in;
        r_wr  = write_rsd_in & (rsd_in != 5'd0);
        case (cmdtype_in)
            CMD_LUI:   r_alu = imm_in;
            CMD_AUIPC: r_alu = pc_in + imm_in;
            CMD_JAL:   begin r_alu = pc_in + 32'd4; r_br = 1'b1; end
            CMD_JALR:  begin r_alu = pc_in + 32'd4; r_br = 1'b1; r_tgt = sum_ri & ~32'd1; end
            CMD_BEQ:   begin r_br = reg1_in == reg2_in; r_wr = 1'b0; end
            CMD_BNE:   begin r_br = reg1_in != reg2_in; r_wr = 1'b0; end
            CMD_BLT:   begin r_br = $signed(reg1_in) < $signed(reg2_in); r_wr = 1'b0; end
            CMD_BGE:   begin r_br = $signed(reg1_in) >= $signed(reg2_in); r_wr = 1'b0; end
            CMD_BLTU:  begin r_br = reg1_in < reg2_in; r_wr = 1'b0; end
            CMD_BGEU:  begin r_br = reg1_in >= reg2_in; r_wr = 1'b0; end
            CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU: r_alu = sum_ri;
            CMD_SB, CMD_SH, CMD_SW: r_wr = 1'b0;
            CMD_ADDI:  r_alu = sum_ri;
            CMD_SLTI:  r_alu = {31'd0, $signed(reg1_in) < $signed(imm_in)};
            CMD_SLTIU: r_alu = {31'd0, reg1_in < imm_in};
            CMD_XORI:  r_alu = reg1_in ^ imm_in;
            CMD_ORI:   r_alu = reg1_in | imm_in;
            CMD_ANDI:  r_alu = reg1_in & imm_in;
            CMD_ADD:   r_alu = reg1_in + reg2_in;
            CMD_SUB:   r_alu = reg1_in - reg2_in;
            CMD_SLT:   r_alu = {31'd0, $signed(reg1_in) < $signed(reg2_in)};
            CMD_SLTU:  r_alu = {31'd0, reg1_in < reg2_in};
            CMD_XOR:   r_alu = reg1_in ^ reg2_in;
            CMD_OR:    r_alu = reg1_in | reg2_in;
            CMD_AND:   r_alu = reg1_in & reg2_in;
            default:   r_alu = '0;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        wr_d      = wr_q;
        br_d      = br_q;
        cmd_d     = cmd_q;
        rsd_d     = rsd_q;
        alu_d     = alu_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        tgt_d     = tgt_q;
        sh_val_d  = sh_val_q;
        sh_rem_d  = sh_rem_q;
        sh_mode_d = sh_mode_q;
        if (state_q == SHIFT) begin
            sh_val_d = sh_next;
            sh_rem_d = rem_next;
            if (sh_done) begin
                valid_d = 1'b1;
                alu_d   = sh_next;
            end
        end else if (valid_q & ~mem_ready_in) begin
            br_d = 1'b0;
        end else begin
            valid_d = 1'b0;
            br_d    = 1'b0;
            if (take) begin
                cmd_d   = cmdtype_in;
                rsd_d   = rsd_in;
                wr_d    = r_wr;
                addr_d  = sum_ri;
                sdata_d = reg2_in;
                tgt_d   = r_tgt;
                if (is_shift) begin
                    sh_val_d  = reg1_in;
                    sh_rem_d  = shamt;
                    sh_mode_d = mode;
                end else begin
                    valid_d = 1'b1;
                    alu_d   = r_alu;
                    br_d    = r_br;
                end
            end
        end
    end

    assign stall_out         = stall;
    assign valid_out         = valid_q;
    assign cmdtype_out       = cmd_q;
    assign rsd_out           = rsd_q;
    assign write_rsd_out     = wr_q;
    assign alu_out           = alu_q;
    assign mem_addr_out      = addr_q;
    assign store_data_out    = sdata_q;
    assign branch_taken_out  = br_q;
    assign branch_target_out = tgt_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table plus hand sequences for the execute stage.
module tb_ex_stage;
    localparam logic [5:0] CMD_LUI = 6'd1, CMD_AUIPC = 6'd2, CMD_JAL = 6'd3, CMD_JALR = 6'd4,
        CMD_BEQ = 6'd5, CMD_BNE = 6'd6, CMD_BLT = 6'd7, CMD_BGEU = 6'd10, CMD_LW = 6'd13,
        CMD_SW = 6'd18, CMD_SLTIU = 6'd21, CMD_XORI = 6'd22, CMD_ANDI = 6'd24, CMD_SLLI = 6'd25,
        CMD_SRLI = 6'd26, CMD_SRAI = 6'd27, CMD_ADD = 6'd28, CMD_SUB = 6'd29, CMD_SLL = 6'd30,
        CMD_SLT = 6'd31, CMD_SLTU = 6'd32, CMD_SRL = 6'd34, CMD_SRA = 6'd35;

    logic        clk_in = 1'b0, rst_in = 1'b0;
    logic [31:0] reg1_in, reg2_in, imm_in, pc_in;
    logic [4:0]  rsd_in;
    logic        write_rsd_in, mem_ready_in;
    logic [5:0]  cmdtype_in;
    logic        stall_out, valid_out, write_rsd_out, branch_taken_out;
    logic [5:0]  cmdtype_out;
    logic [4:0]  rsd_out;
    logic [31:0] alu_out, mem_addr_out, store_data_out, branch_target_out;

    always #5 clk_in = ~clk_in;

    ex_stage #(.SHIFT_STEP(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .reg1_in(reg1_in), .reg2_in(reg2_in),
        .imm_in(imm_in), .pc_in(pc_in), .rsd_in(rsd_in), .write_rsd_in(write_rsd_in),
        .cmdtype_in(cmdtype_in), .mem_ready_in(mem_ready_in), .stall_out(stall_out),
        .valid_out(valid_out), .cmdtype_out(cmdtype_out), .rsd_out(rsd_out),
        .write_rsd_out(write_rsd_out), .alu_out(alu_out), .mem_addr_out(mem_addr_out),
        .store_data_out(store_data_out), .branch_taken_out(branch_taken_out),
        .branch_target_out(branch_target_out)
    );

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] r1, r2, imm, pc;
        logic [4:0]  rsd;
        logic        wr;
        logic [31:0] alu;
        logic        ca;
        logic [31:0] addr;
        logic        cm;
        logic [31:0] sd;
        logic        ewr, br;
        logic [31:0] tgt;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] c, input logic [31:0] r1, r2, imm, pc,
                         input logic [4:0] rsd, input logic wr);
        cmdtype_in = c; reg1_in = r1; reg2_in = r2; imm_in = imm; pc_in = pc;
        rsd_in = rsd; write_rsd_in = wr;
    endtask

    function automatic void add(input logic [5:0] c, input logic [31:0] r1, r2, imm, pc,
                                input logic [4:0] rsd, input logic wr, input logic [31:0] alu,
                                input logic ca, input logic [31:0] addr, input logic cm,
                                input logic [31:0] sd, input logic ewr, br,
                                input logic [31:0] tgt, input int lat);
        vec_t v;
        v.cmd = c; v.r1 = r1; v.r2 = r2; v.imm = imm; v.pc = pc; v.rsd = rsd; v.wr = wr;
        v.alu = alu; v.ca = ca; v.addr = addr; v.cm = cm; v.sd = sd; v.ewr = ewr;
        v.br = br; v.tgt = tgt; v.lat = lat;
        vecs.push_back(v);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(6'd0, 0, 0, 0, 0, 0, 0);
        mem_ready_in = 1'b1;
        #2;
        chk("rst valid", 32'(valid_out), 0);
        chk("rst stall", 32'(stall_out), 0);
        chk("rst alu", alu_out, 0);
        chk("rst target", branch_target_out, 0);
        #1 rst_in = 1'b1;

        //   cmd        r1            r2            imm           pc       rsd wr alu          ca addr       cm sd           ewr br tgt     lat
        add(CMD_ADD,   32'hFFFFFFFF, 32'd2,        0,            0,       5, 1, 32'd1,       1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_SUB,   32'd5,        32'd7,        0,            0,       6, 1, 32'hFFFFFFFE,1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_SLT,   32'hFFFFFFFF, 32'd1,        0,            0,       7, 1, 32'd1,       1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_SLTU,  32'hFFFFFFFF, 32'd1,        0,            0,       7, 1, 32'd0,       1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_SLTIU, 32'd1,        0,            32'hFFFFFFFF, 0,       8, 1, 32'd1,       1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_XORI,  32'hF0F0,     0,            32'hFF,       0,       8, 1, 32'hF00F,    1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_ANDI,  32'hFF00FF00, 0,            32'hFFFFF0F0, 0,       8, 1, 32'hFF00F000,1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_LUI,   0,            0,            32'h12345000, 0,       9, 1, 32'h12345000,1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_AUIPC, 0,            0,            32'h1000,     32'h100, 9, 1, 32'h1100,    1, 0,         0, 0,           1, 0, 0,        1);
        add(CMD_JAL,   0,            0,            32'h20,       32'h40,  1, 1, 32'h44,      1, 0,         0, 0,           1, 1, 32'h60,   1);
        add(CMD_JALR,  32'h1003,     0,            32'd2,        32'h40,  0, 1, 32'h44,      1, 0,         0, 0,           0, 1, 32'h1004, 1);
        add(CMD_BLT,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFF8, 32'h100, 3, 1, 0,           0, 0,         0, 0,           0, 1, 32'hF8,   1);
        add(CMD_BGEU,  32'd1,        32'hFFFFFFFF, 32'h10,       32'h100, 3, 1, 0,           0, 0,         0, 0,           0, 0, 0,        1);
        add(CMD_BNE,   32'd5,        32'd5,        32'h10,       32'h200, 3, 1, 0,           0, 0,         0, 0,           0, 0, 0,        1);
        add(CMD_BEQ,   32'd5,        32'd5,        32'h10,       32'h200, 3, 1, 0,           0, 0,         0, 0,           0, 1, 32'h210,  1);
        add(CMD_LW,    32'h1000,     0,            32'hFFFFFFFC, 0,       9, 1, 0,           0, 32'hFFC,   1, 0,           1, 0, 0,        1);
        add(CMD_SW,    32'h2000,     32'hDEADBEEF, 32'd8,        0,       8, 1, 0,           0, 32'h2008,  1, 32'hDEADBEEF,0, 0, 0,        1);
        add(CMD_ADD,   32'd1,        32'd1,        0,            0,       0, 1, 32'd2,       1, 0,         0, 0,           0, 0, 0,        1);
        add(CMD_SRAI,  32'h80000000, 0,            32'd9,        0,       4, 1, 32'hFFC00000,1, 0,         0, 0,           1, 0, 0,        4);
        add(CMD_SLL,   32'd1,        32'd31,       0,            0,       4, 1, 32'h80000000,1, 0,         0, 0,           1, 0, 0,        9);
        add(CMD_SRL,   32'h80000000, 32'h24,       0,            0,       4, 1, 32'h08000000,1, 0,         0, 0,           1, 0, 0,        2);
        add(CMD_SLLI,  32'h1234,     0,            32'd0,        0,       4, 1, 32'h1234,    1, 0,         0, 0,           1, 0, 0,        2);
        add(CMD_SRA,   32'h7FFFFFFF, 32'd3,        0,            0,       4, 1, 32'h0FFFFFFF,1, 0,         0, 0,           1, 0, 0,        2);
        add(CMD_SRA,   32'h80000010, 32'd4,        0,            0,       4, 1, 32'hF8000001,1, 0,         0, 0,           1, 0, 0,        2);
        add(CMD_SRLI,  32'hFFFFFFFF, 0,            32'd31,       0,       4, 1, 32'd1,       1, 0,         0, 0,           1, 0, 0,        9);

        foreach (vecs[i]) begin
            int n;
            n = 0;
            drive(vecs[i].cmd, vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].pc, vecs[i].rsd, vecs[i].wr);
            do begin
                step();
                cmdtype_in = 6'd0;
                n++;
            end while (!valid_out && n < 20);
            chk($sformatf("v%0d latency", i), 32'(n), 32'(vecs[i].lat));
            chk($sformatf("v%0d valid", i), 32'(valid_out), 1);
            chk($sformatf("v%0d cmd", i), 32'(cmdtype_out), 32'(vecs[i].cmd));
            chk($sformatf("v%0d rsd", i), 32'(rsd_out), 32'(vecs[i].rsd));
            chk($sformatf("v%0d wr", i), 32'(write_rsd_out), 32'(vecs[i].ewr));
            chk($sformatf("v%0d br", i), 32'(branch_taken_out), 32'(vecs[i].br));
            if (vecs[i].ca) chk($sformatf("v%0d alu", i), alu_out, vecs[i].alu);
            if (vecs[i].cm) begin
                chk($sformatf("v%0d addr", i), mem_addr_out, vecs[i].addr);
                chk($sformatf("v%0d sdata", i), store_data_out, vecs[i].sd);
            end
            if (vecs[i].br) chk($sformatf("v%0d target", i), branch_target_out, vecs[i].tgt);
            step();
            chk($sformatf("v%0d valid drop", i), 32'(valid_out), 0);
            chk($sformatf("v%0d br drop", i), 32'(branch_taken_out), 0);
        end

        // SRAI by 9: three stall cycles, result on the fourth edge
        drive(CMD_SRAI, 32'h80000000, 0, 32'd9, 0, 4, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            cmdtype_in = 6'd0;
            chk($sformatf("srai stall%0d", k), 32'(stall_out), 1);
            chk($sformatf("srai nvalid%0d", k), 32'(valid_out), 0);
        end
        step();
        chk("srai stall end", 32'(stall_out), 0);
        chk("srai valid", 32'(valid_out), 1);
        chk("srai alu", alu_out, 32'hFFC00000);
        step();

        // taken branch, then an ADD at the pulse edge is killed
        drive(CMD_BLT, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 32'h100, 3, 1);
        step();
        chk("kill br", 32'(branch_taken_out), 1);
        chk("kill target", branch_target_out, 32'hF8);
        drive(CMD_ADD, 32'd1, 32'd1, 0, 0, 5, 1);
        step();
        chk("kill valid", 32'(valid_out), 0);
        chk("kill br pulse", 32'(branch_taken_out), 0);
        cmdtype_in = 6'd0;
        step();
        chk("kill valid2", 32'(valid_out), 0);

        // back-pressure on a load, then back-to-back ADDs
        mem_ready_in = 1'b0;
        drive(CMD_LW, 32'h100, 0, 32'd4, 0, 9, 1);
        step();
        chk("bp valid0", 32'(valid_out), 1);
        chk("bp addr0", mem_addr_out, 32'h104);
        chk("bp stall0", 32'(stall_out), 1);
        drive(CMD_ADD, 32'd3, 32'd4, 0, 0, 2, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("bp valid%0d", k + 1), 32'(valid_out), 1);
            chk($sformatf("bp addr%0d", k + 1), mem_addr_out, 32'h104);
            chk($sformatf("bp stall%0d", k + 1), 32'(stall_out), 1);
            chk($sformatf("bp cmd%0d", k + 1), 32'(cmdtype_out), 32'(CMD_LW));
        end
        mem_ready_in = 1'b1;
        #1;
        chk("bp stall release", 32'(stall_out), 0);
        step();
        chk("b2b valid", 32'(valid_out), 1);
        chk("b2b cmd", 32'(cmdtype_out), 32'(CMD_ADD));
        chk("b2b alu", alu_out, 32'd7);
        drive(CMD_ADD, 32'd10, 32'd20, 0, 0, 3, 1);
        step();
        chk("b2b valid2", 32'(valid_out), 1);
        chk("b2b alu2", alu_out, 32'd30);
        cmdtype_in = 6'd0;
        step();
        chk("b2b drop", 32'(valid_out), 0);

        // reset in the middle of a 31-bit shift
        drive(CMD_SLL, 32'd1, 32'd31, 0, 0, 4, 1);
        step();
        cmdtype_in = 6'd0;
        step();
        chk("rs stall", 32'(stall_out), 1);
        rst_in = 1'b0;
        #1;
        chk("rs valid", 32'(valid_out), 0);
        chk("rs alu", alu_out, 0);
        chk("rs cmd", 32'(cmdtype_out), 0);
        chk("rs rsd", 32'(rsd_out), 0);
        chk("rs stall0", 32'(stall_out), 0);
        #1 rst_in = 1'b1;
        drive(CMD_ADD, 32'd2, 32'd3, 0, 0, 5, 1);
        step();
        chk("rs add valid", 32'(valid_out), 1);
        chk("rs add alu", alu_out, 32'd5);
        cmdtype_in = 6'd0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
